io_handshake_unit: RTL

Human-interface I/O stage that produces the `flag` stall input for the main controller and consumes its `in`/`out` decode strobes.
- While an `in` or `out` instruction is in flight, it holds `flag` high until the operator confirms with a debounced push-button. This freezes the single-cycle core, because the controller asserts halt while `flag` is high.
- On confirmation it captures the switch value (for `in`) or the value to show (for `out`), then drops `flag` for exactly one cycle so the instruction commits.

---
 rtl/io_pkg.sv | 15 +
 rtl/button_debouncer.sv | 62 ++++++
 rtl/io_handshake_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the operator I/O handshake stage: state encoding
// and default datapath widths.
package io_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SW_W_DEF   = 18;

    typedef logic [1:0] state_t;

    localparam state_t IDLE         = 2'd0;
    localparam state_t WAIT_PRESS   = 2'd1;
    localparam state_t WAIT_RELEASE = 2'd2;
    localparam state_t DONE         = 2'd3;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter for one raw operator button;
// yields a clean level and a one-cycle rising-edge pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_clean,
    output logic btn_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             clean_r;
    logic             clean_q_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronizer chain for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Clean level only flips after the synchronized level disagrees for the full window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            clean_r <= 1'b0;
        end else if (sync2_r != clean_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                clean_r <= ~clean_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= '0;
        end
    end

    // Delayed clean level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q_r <= 1'b0;
        end else begin
            clean_q_r <= clean_r;
        end
    end

    assign btn_clean = clean_r;
    assign btn_rise  = clean_r & ~clean_q_r;

endmodule

// File: rtl/io_handshake_unit.sv
// Operator handshake for `in`/`out` instructions: stalls the core via flag
// until a debounced confirm press, captures data, then releases for one cycle.
module io_handshake_unit
    import io_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int SW_W            = SW_W_DEF,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_in_req,
    input  logic              io_out_req,
    input  logic [SW_W-1:0]   switches,
    input  logic              confirm_btn,
    input  logic [DATA_W-1:0] out_data,
    output logic              flag,
    output logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] display_data,
    output logic              display_valid,
    output logic              busy
);

    state_t            state_r;
    state_t            next_state_s;
    logic              req_s;
    logic              capture_s;
    logic              btn_clean_s;
    logic              btn_rise_s;
    logic              flag_s;
    logic              busy_s;
    logic [DATA_W-1:0] in_data_r;
    logic [DATA_W-1:0] display_data_r;
    logic              display_valid_r;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_confirm_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (confirm_btn),
        .btn_clean(btn_clean_s),
        .btn_rise (btn_rise_s)
    );

    assign req_s     = io_in_req | io_out_req;
    assign capture_s = (state_r == WAIT_PRESS) & req_s & btn_rise_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a dropped request always aborts back to IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) next_state_s = WAIT_PRESS;
                else       next_state_s = IDLE;
            end
            WAIT_PRESS: begin
                if (!req_s)          next_state_s = IDLE;
                else if (btn_rise_s) next_state_s = WAIT_RELEASE;
                else                 next_state_s = WAIT_PRESS;
            end
            WAIT_RELEASE: begin
                if (!req_s)            next_state_s = IDLE;
                else if (!btn_clean_s) next_state_s = DONE;
                else                   next_state_s = WAIT_RELEASE;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Outputs; flag stays combinational so the stall lands in the request's first cycle
    always_comb begin
        flag_s = 1'b0;
        busy_s = 1'b0;
        case (state_r)
            IDLE: begin
                flag_s = req_s;
                busy_s = 1'b0;
            end
            WAIT_PRESS, WAIT_RELEASE: begin
                flag_s = req_s;
                busy_s = 1'b1;
            end
            DONE: begin
                flag_s = 1'b0;
                busy_s = 1'b1;
            end
            default: begin
                flag_s = 1'b0;
                busy_s = 1'b0;
            end
        endcase
    end

    // Captured data; `in` wins when both requests are decoded together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_data_r       <= '0;
            display_data_r  <= '0;
            display_valid_r <= 1'b0;
        end else if (capture_s) begin
            if (io_in_req) begin
                in_data_r <= DATA_W'(switches);
            end else begin
                display_data_r  <= out_data;
                display_valid_r <= 1'b1;
            end
        end else begin
            in_data_r       <= in_data_r;
            display_data_r  <= display_data_r;
            display_valid_r <= display_valid_r;
        end
    end

    assign flag          = flag_s;
    assign busy          = busy_s;
    assign in_data       = in_data_r;
    assign display_data  = display_data_r;
    assign display_valid = display_valid_r;

endmodule
